conv_pe_mac: RTL and testbench
==============================

Name: conv_pe_mac

Overview:
Parametrised multi-channel convolution MAC processing element, next generation of the CNN conv PE.
- Accepts one beat per cycle. Each beat carries CH input-feature/weight pairs.
- Accumulates KERNEL_SIZE beats per output window.
- Requantises the sum to DW-bit fixed point with rounding, bias add and saturation.
- Sits between the line-buffer/weight feeder (upstream) and the pooling stage (downstream), with valid/ready handshakes on both sides.

Parameters:
- CH, 3, input channels per beat (>=1)
- KERNEL_SIZE, 9, beats accumulated per output (>=1)
- DW, 16, signed data/weight/bias/output width
- FRAC, 10, fractional bits of the fixed-point format (1..DW-1)

Ports:
- clk  in  1  clock
- n_reset  in  1  asynchronous, active-low reset
- start  in  1  enable; low aborts and clears the PE
- in_valid  in  1  upstream beat valid
- in_ready  out  1  PE accepts a beat this cycle
- ifmap  in  CH x DW signed  input feature values, index 0..CH-1
- weight  in  CH x DW signed  weights, index 0..CH-1
- bias  in  DW signed  bias, sampled when the last beat of a window is accepted
- out_valid  out  1  result valid
- out_ready  in  1  downstream (pool) accepts the result
- out_data  out  DW signed  requantised result, registered

Behaviour:
- Reset is n_reset, asynchronous, active-low; clock is clk.
- Reset values: state=IDLE, count=0, acc=0, in_ready=0, out_valid=0, out_data=0.
- Widths:
  - PW = 2*DW (product width).
  - ACCW = 2*DW + clog2(CH*KERNEL_SIZE) + 1. The accumulator never overflows.
- States:
  - IDLE: in_ready=0. If start=1, go to ACC next cycle.
  - ACC: in_ready=1.
    - A beat is accepted when in_valid & in_ready.
    - On accept: acc += sum over c of ifmap[c]*weight[c], all products signed and full-width; count += 1.
    - On the accept where count==KERNEL_SIZE-1: compute the final sum including this beat, latch result=requant(final sum, bias) into out_data, clear acc and count, go to OUT.
  - OUT: in_ready=0, out_valid=1. out_data is held stable until out_ready=1. On out_valid & out_ready, go to ACC if start=1, else IDLE.
- Latency: out_valid rises the cycle after the last beat is accepted.
- Minimum throughput: one result per KERNEL_SIZE+1 cycles.
- Stalls: in_valid=0 in ACC holds acc and count unchanged. No beat is ever dropped or double-counted.
- requant(s, b):
  - r = (s + 2^(FRAC-1)) >>> FRAC (round half up, arithmetic shift).
  - r += sign-extended b.
  - Saturate to [-2^(DW-1), 2^(DW-1)-1].
- start=0 in any state: next cycle go to IDLE; acc=0, count=0, out_valid=0. A pending result is discarded.
- start=0 has priority over a simultaneous accept or output handshake.
- n_reset asserted mid-window returns all registers to reset values immediately.
- KERNEL_SIZE=1: every accepted beat produces a result.

Optional Feature:
- Macro CONV_PE_RELU_EN.
- Defined: after saturation, negative results are forced to 0, so out_data is in [0, 2^(DW-1)-1].
- Undefined: the signed saturated result is output unchanged.
- Bias add and rounding are identical in both builds.

Decomposition:
- Package conv_pe_pkg:
  - state enum (IDLE, ACC, OUT)
  - function acc_width(DW, CH, KERNEL_SIZE)
  - function sat_dw, which saturates a wide signed value to DW bits
- Sub-module conv_pe_requant: purely combinational. Performs round, shift, bias add, saturate and the optional ReLU. Parameterised by DW, FRAC and ACCW.
- The top holds the FSM, counter, accumulator and handshakes.

Test Plan (DW=16, FRAC=10, CH=3, KERNEL_SIZE=9 unless noted):
- Basic: all ifmap=1024, weight=1024, bias=0, 9 back-to-back beats, out_ready=1 -> out_data=27648; out_valid for 1 cycle, the cycle after beat 9.
- Bias and negative: weight=-1024, ifmap=1024, bias=100 -> out_data=-27548. With CONV_PE_RELU_EN defined -> 0.
- Saturation: ifmap=32767, weight=32767 -> out_data=32767. Same with weight=-32768 -> out_data=-32768.
- Rounding, KERNEL_SIZE=1, CH=1: ifmap=1, weight=512 (sum=512) -> out_data=1. ifmap=1, weight=511 -> out_data=0.
- Backpressure/stall: random in_valid gaps, and out_ready held low for 5 cycles -> result equals the no-stall value; out_data stable while stalled; in_ready=0 in OUT.
- Abort: deassert start after 4 beats, reassert, then send 9 beats of ifmap=1024, weight=1024 -> out_data=27648 (the earlier partial sum is discarded). Also n_reset asserted mid-window -> all outputs 0 immediately.

Source files
------------

// File: rtl/conv_pe_pkg.sv
// conv_pe_pkg: shared types and helpers for the convolution MAC processing element.
//   state_t   - PE control states (IDLE, ACC, OUT)
//   acc_width - accumulator width that cannot overflow for CH*KERNEL_SIZE products
//   sat_dw    - clamps a wide signed value into the signed dw-bit range
package conv_pe_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Working width for sat_dw; every requant intermediate fits well inside it.
    localparam int SAT_W = 128;

    function automatic int acc_width(input int dw, input int ch, input int ks);
        return 2 * dw + $clog2(ch * ks) + 1;
    endfunction

    // Result is SAT_W wide; the caller keeps the low dw bits.
    function automatic logic signed [SAT_W-1:0] sat_dw(input logic signed [SAT_W-1:0] v,
                                                       input int dw);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = $signed((SAT_W'(1) << (dw - 1)) - SAT_W'(1));
        lo = ~hi;  // two's complement: ~max == min
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/conv_pe_requant.sv
// conv_pe_requant: combinational requantiser for the conv PE.
//   result = sat_DW(((sum + 2^(FRAC-1)) >>> FRAC) + bias), optionally ReLU'd.
// Ports:
//   sum    in  ACCW signed  full-precision window sum
//   bias   in  DW signed    bias added after the shift
//   result out DW signed    requantised value
// Build option: define CONV_PE_RELU_EN to clamp negative results to zero.
module conv_pe_requant
    import conv_pe_pkg::*;
#(
    parameter int DW   = 16,
    parameter int FRAC = 10,
    parameter int ACCW = 38
) (
    input  logic signed [ACCW-1:0] sum,
    input  logic signed [DW-1:0]   bias,
    output logic signed [DW-1:0]   result
);

    // One guard bit so the rounding offset can never wrap the sum.
    localparam int RW = ACCW + 1;
    localparam logic signed [RW-1:0] HALF = RW'(1) << (FRAC - 1);

    logic signed [RW-1:0]    rnd;
    logic signed [RW-1:0]    shr;
    logic signed [RW-1:0]    biased;
    logic signed [SAT_W-1:0] sat;
    logic                    sat_unused;

    always_comb begin
        rnd    = $signed({sum[ACCW-1], sum}) + HALF;
        shr    = rnd >>> FRAC;
        biased = shr + $signed({{(RW-DW){bias[DW-1]}}, bias});
        sat    = sat_dw($signed({{(SAT_W-RW){biased[RW-1]}}, biased}), DW);
`ifdef CONV_PE_RELU_EN
        result = sat[SAT_W-1] ? '0 : sat[DW-1:0];
`else
        result = sat[DW-1:0];
`endif
    end

    // Upper bits are pure sign extension once saturated.
    assign sat_unused = ^sat[SAT_W-1:DW];

endmodule

// File: rtl/conv_pe_mac.sv
// conv_pe_mac: multi-channel convolution MAC processing element.
// Accumulates KERNEL_SIZE beats of CH ifmap*weight products, then emits one
// requantised DW-bit result through a valid/ready output port.
// Ports:
//   clk, n_reset           clock, asynchronous active-low reset
//   start                  enable; low aborts the current window / pending result
//   in_valid, in_ready     upstream beat handshake
//   ifmap[CH], weight[CH]  signed beat operands
//   bias                   signed bias, taken with the last beat of a window
//   out_valid, out_ready   downstream result handshake
//   out_data               registered signed result
// Build option: CONV_PE_RELU_EN (see conv_pe_requant).
module conv_pe_mac
    import conv_pe_pkg::*;
#(
    parameter int CH          = 3,
    parameter int KERNEL_SIZE = 9,
    parameter int DW          = 16,
    parameter int FRAC        = 10
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] ifmap  [CH],
    input  logic signed [DW-1:0] weight [CH],
    input  logic signed [DW-1:0] bias,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_data
);

    localparam int PW   = 2 * DW;
    localparam int ACCW = acc_width(DW, CH, KERNEL_SIZE);
    localparam int CW   = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
    localparam logic [CW-1:0] LAST = CW'(KERNEL_SIZE - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [CW-1:0]          count;
    logic signed [ACCW-1:0] acc;
    logic signed [ACCW-1:0] beat_sum;
    logic signed [ACCW-1:0] final_sum;
    logic signed [PW-1:0]   prod;
    logic signed [DW-1:0]   req_res;
    logic                   accept;
    logic                   last_beat;

    // Sum of this beat's CH full-width signed products.
    always_comb begin
        prod     = '0;
        beat_sum = '0;
        for (int c = 0; c < CH; c++) begin
            prod     = $signed({{DW{ifmap[c][DW-1]}}, ifmap[c]}) *
                       $signed({{DW{weight[c][DW-1]}}, weight[c]});
            beat_sum = beat_sum + $signed({{(ACCW-PW){prod[PW-1]}}, prod});
        end
    end

    assign final_sum = acc + beat_sum;
    assign accept    = in_valid && in_ready;
    assign last_beat = accept && (count == LAST);

    conv_pe_requant #(
        .DW   (DW),
        .FRAC (FRAC),
        .ACCW (ACCW)
    ) u_requant (
        .sum    (final_sum),
        .bias   (bias),
        .result (req_res)
    );

    // Next state and handshake outputs; start=0 overrides everything.
    always_comb begin
        state_nxt = state;
        in_ready  = (state == ACC) && start;
        out_valid = (state == OUT);
        if (!start) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = ACC;
                ACC:     if (last_beat) state_nxt = OUT;
                OUT:     if (out_ready) state_nxt = ACC;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            acc      <= '0;
            count    <= '0;
            out_data <= '0;
        end else if (!start) begin
            acc   <= '0;
            count <= '0;
        end else if (accept) begin
            if (last_beat) begin
                acc      <= '0;
                count    <= '0;
                out_data <= req_res;
            end else begin
                acc   <= final_sum;
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_conv_pe_mac.sv
module tb_conv_pe_mac;

    localparam int FRAC = 10;

    logic clk = 1'b0;
    logic n_reset;
    logic start;
    logic in_valid;
    logic in_ready;
    logic signed [15:0] ifmap  [3];
    logic signed [15:0] weight [3];
    logic signed [15:0] bias;
    logic out_valid;
    logic out_ready;
    logic signed [15:0] out_data;

    // Second instance: CH=1, KERNEL_SIZE=1 for rounding corners.
    logic s_start;
    logic s_in_valid;
    logic s_in_ready;
    logic signed [15:0] s_ifmap  [1];
    logic signed [15:0] s_weight [1];
    logic signed [15:0] s_bias;
    logic s_out_valid;
    logic s_out_ready;
    logic signed [15:0] s_out_data;

    int checks = 0;
    int errors = 0;

    logic signed [15:0] bw_if [9][3];
    logic signed [15:0] bw_w  [9][3];
    logic signed [15:0] bias_v;

    always #5 clk = ~clk;

    conv_pe_mac #(.CH(3), .KERNEL_SIZE(9), .DW(16), .FRAC(FRAC)) dut (
        .clk(clk), .n_reset(n_reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .ifmap(ifmap), .weight(weight), .bias(bias),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    conv_pe_mac #(.CH(1), .KERNEL_SIZE(1), .DW(16), .FRAC(FRAC)) dut1 (
        .clk(clk), .n_reset(n_reset), .start(s_start),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .ifmap(s_ifmap), .weight(s_weight), .bias(s_bias),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference requantiser: floor division for the rounding shift.
    function automatic longint requant_ref(input longint s, input longint b);
        longint t, q;
        t = s + (longint'(1) << (FRAC - 1));
        q = t / (longint'(1) << FRAC);
        if ((t % (longint'(1) << FRAC)) != 0 && t < 0) q = q - 1;
        q = q + b;
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
`ifdef CONV_PE_RELU_EN
        if (q < 0) q = 0;
`endif
        return q;
    endfunction

    function automatic longint window_ref();
        longint s = 0;
        for (int b = 0; b < 9; b++)
            for (int c = 0; c < 3; c++)
                s += longint'(bw_if[b][c]) * longint'(bw_w[b][c]);
        return requant_ref(s, longint'(bias_v));
    endfunction

    task automatic fill_const(input logic signed [15:0] a, input logic signed [15:0] w,
                              input logic signed [15:0] b);
        for (int i = 0; i < 9; i++)
            for (int c = 0; c < 3; c++) begin
                bw_if[i][c] = a;
                bw_w[i][c]  = w;
            end
        bias_v = b;
    endtask

    task automatic fill_rand(input int span);
        for (int i = 0; i < 9; i++)
            for (int c = 0; c < 3; c++) begin
                if (span == 0) begin
                    bw_if[i][c] = 16'($urandom);
                    bw_w[i][c]  = 16'($urandom);
                end else begin
                    bw_if[i][c] = 16'(int'($urandom_range(0, 2 * span)) - span);
                    bw_w[i][c]  = 16'(int'($urandom_range(0, 2 * span)) - span);
                end
            end
        bias_v = 16'($urandom);
    endtask

    task automatic send_beats(input int n, input int gap_pct);
        int sent = 0;
        int guard = 0;
        bias = bias_v;
        while (sent < n && guard < 2000) begin
            @(negedge clk);
            guard++;
            for (int c = 0; c < 3; c++) begin
                ifmap[c]  = bw_if[sent][c];
                weight[c] = bw_w[sent][c];
            end
            in_valid = ($urandom_range(0, 99) >= gap_pct);
            if (in_valid && in_ready) sent++;
        end
        if (sent != n) chk("beat_timeout", sent, n);
    endtask

    task automatic run_window(input int gap_pct, input int hold, input longint exp_v,
                              input string tag);
        out_ready = (hold == 0);
        send_beats(9, gap_pct);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_vld"}, out_valid, 1);
        chk({tag, "_inrdy"}, in_ready, 0);
        chk({tag, "_data"}, out_data, exp_v);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_stall_vld"}, out_valid, 1);
            chk({tag, "_stall_data"}, out_data, exp_v);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_vld_drop"}, out_valid, 0);
    endtask

    task automatic single(input logic signed [15:0] a, input logic signed [15:0] w,
                          input logic signed [15:0] b, input string tag);
        longint e;
        e = requant_ref(longint'(a) * longint'(w), longint'(b));
        @(negedge clk);
        s_ifmap[0]  = a;
        s_weight[0] = w;
        s_bias      = b;
        s_in_valid  = 1'b1;
        chk({tag, "_rdy"}, s_in_ready, 1);
        @(negedge clk);
        s_in_valid = 1'b0;
        chk({tag, "_vld"}, s_out_valid, 1);
        chk({tag, "_data"}, s_out_data, e);
        @(negedge clk);
        chk({tag, "_vld_drop"}, s_out_valid, 0);
    endtask

    initial begin
        n_reset = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1; bias = '0;
        s_start = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b1; s_bias = '0;
        s_ifmap[0] = '0; s_weight[0] = '0;
        for (int c = 0; c < 3; c++) begin ifmap[c] = '0; weight[c] = '0; end
        fill_const(16'sd0, 16'sd0, 16'sd0);

        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        n_reset = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 0);
        start = 1'b1;
        s_start = 1'b1;
        @(negedge clk);
        chk("acc_in_ready", in_ready, 1);

        fill_const(16'sd1024, 16'sd1024, 16'sd0);
        run_window(0, 0, 27648, "basic");

        fill_const(16'sd1024, -16'sd1024, 16'sd100);
`ifdef CONV_PE_RELU_EN
        run_window(0, 0, 0, "neg_bias");
`else
        run_window(0, 0, -27548, "neg_bias");
`endif

        fill_const(16'sd32767, 16'sd32767, 16'sd0);
        run_window(0, 0, 32767, "sat_pos");
        fill_const(16'sd32767, -16'sd32768, 16'sd0);
`ifdef CONV_PE_RELU_EN
        run_window(0, 0, 0, "sat_neg");
`else
        run_window(0, 0, -32768, "sat_neg");
`endif

        fill_const(16'sd1024, 16'sd1024, 16'sd0);
        run_window(40, 5, 27648, "stall");

        for (int k = 0; k < 6; k++) begin
            fill_rand((k % 3 == 0) ? 0 : ((k % 3 == 1) ? 500 : 3000));
            run_window(30, k % 4, window_ref(), "rand");
        end

        // Abort mid-window: the partial sum must be discarded.
        fill_const(16'sd2000, 16'sd2000, 16'sd0);
        send_beats(4, 0);
        @(negedge clk);
        in_valid = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", in_ready, 0);
        chk("abort_out_valid", out_valid, 0);
        start = 1'b1;
        fill_const(16'sd1024, 16'sd1024, 16'sd0);
        run_window(0, 0, 27648, "abort");

        // Abort while a result is pending.
        out_ready = 1'b0;
        send_beats(9, 0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("pend_vld", out_valid, 1);
        start = 1'b0;
        @(negedge clk);
        chk("pend_drop", out_valid, 0);
        start = 1'b1;
        out_ready = 1'b1;
        fill_rand(400);
        run_window(20, 0, window_ref(), "after_pend");

        // Asynchronous reset in the middle of a window.
        fill_const(16'sd1024, 16'sd1024, 16'sd0);
        send_beats(4, 0);
        @(negedge clk);
        in_valid = 1'b0;
        #2 n_reset = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0);
        @(negedge clk);
        n_reset = 1'b1;
        run_window(0, 0, 27648, "post_rst");

        // Rounding corners with CH=1, KERNEL_SIZE=1.
        repeat (2) @(negedge clk);
        single(16'sd1, 16'sd512, 16'sd0, "rnd_half");
        single(16'sd1, 16'sd511, 16'sd0, "rnd_below");
        single(16'sd1, -16'sd513, 16'sd0, "rnd_neg");
        single(16'sd1, 16'sd1536, 16'sd7, "rnd_bias");
        for (int k = 0; k < 4; k++)
            single(16'($urandom), 16'($urandom), 16'($urandom), "rnd_rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
